// File: rtl/demux4_buf.sv
// rtl/demux4_buf.sv - 1-to-4 registered demultiplexer with per-channel one-entry buffers
//
// Steers each accepted input word to one of four channels by in_sel and holds
// it in that channel's one-entry buffer until the channel's consumer takes it.
// A wrap-around count of words accepted for each channel is kept.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   producer offers in_sel/in_data
//   in_ready   block accepts when in_valid & in_ready
//   in_sel     destination channel 0..3
//   in_data    input word
//   out_valid  bit i: channel i buffer holds a word
//   out_ready  bit i: consumer i takes the word this cycle
//   out_data0..out_data3  buffered word per channel
//   out_cnt    channel i accept count in bits [i*CNT_W +: CNT_W]
module demux4_buf #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [4*CNT_W-1:0]   out_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t          state_q [4];
    ch_state_t          state_d [4];
    logic [WIDTH-1:0]   data_q  [4];
    logic [WIDTH-1:0]   data_d  [4];
    logic [CNT_W-1:0]   cnt_q   [4];
    logic [CNT_W-1:0]   cnt_d   [4];

    logic               accept;
    logic [3:0]         hit;
    logic [3:0]         take;

    // A full channel can still accept when its consumer drains it in the same
    // cycle, which is what gives one word per cycle per channel.
    always_comb begin
        in_ready = !rst && ((state_q[in_sel] == ST_EMPTY) || out_ready[in_sel]);
        accept   = in_valid && in_ready;
        for (int i = 0; i < 4; i++) begin
            hit[i]  = accept && (in_sel == 2'(i));
            take[i] = (state_q[i] == ST_FULL) && out_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_EMPTY: begin
                    // out_ready is ignored while empty
                    if (hit[i]) begin
                        state_d[i] = ST_FULL;
                        data_d[i]  = in_data;
                    end
                end
                ST_FULL: begin
                    if (hit[i]) begin
                        data_d[i]  = in_data;
                    end else if (take[i]) begin
                        // data holds its last value after draining
                        state_d[i] = ST_EMPTY;
                    end
                end
                default: state_d[i] = ST_EMPTY;
            endcase
            if (hit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_EMPTY;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                 = (state_q[i] == ST_FULL);
            out_cnt[i*CNT_W +: CNT_W]    = cnt_q[i];
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

endmodule

// File: tb/tb_demux4_buf.sv
// tb/tb_demux4_buf.sv - scoreboard testbench for demux4_buf
`timescale 1ns/1ps
module tb_demux4_buf;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid;
    logic [1:0]    in_sel;
    logic [W-1:0]  in_data;
    logic [3:0]    out_ready;

    logic          in_ready,  in_ready4;
    logic [3:0]    out_valid, out_valid4;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [W-1:0]  d4_0, d4_1, d4_2, d4_3;
    logic [31:0]   out_cnt;
    logic [15:0]   cnt4;
    logic [W-1:0]  od  [4];
    logic [W-1:0]  od4 [4];

    always #5 clk = ~clk;

    demux4_buf #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3), .out_cnt(out_cnt)
    );

    // Narrow-counter copy on the same inputs, used to observe counter wrap.
    demux4_buf #(.WIDTH(W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data0(d4_0), .out_data1(d4_1),
        .out_data2(d4_2), .out_data3(d4_3), .out_cnt(cnt4)
    );

    assign od[0] = out_data0;  assign od[1] = out_data1;
    assign od[2] = out_data2;  assign od[3] = out_data3;
    assign od4[0] = d4_0;      assign od4[1] = d4_1;
    assign od4[2] = d4_2;      assign od4[3] = d4_3;

    int           n_pass = 0;
    int           n_tot  = 0;
    logic [W-1:0] sbq [4][$];
    int           mcnt [4];
    bit           chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a channel holds a word exactly when its queue is non-empty;
    // counts are plain integers reduced modulo the counter range.
    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [31:0] ec;
        logic [15:0] ec4;
        logic        er;
        if (chk_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                ev[i]        = (sbq[i].size() != 0);
                ec[i*8 +: 8] = 8'(mcnt[i] % 256);
                ec4[i*4 +: 4] = 4'(mcnt[i] % 16);
            end
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_valid_w4", 64'(out_valid4), 64'(ev));
            chk("out_cnt", 64'(out_cnt), 64'(ec));
            chk("out_cnt_w4", 64'(cnt4), 64'(ec4));
            er = (sbq[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", 64'(in_ready), 64'(er));
            chk("in_ready_w4", 64'(in_ready4), 64'(er));
            if (in_valid && er) begin
                sbq[in_sel].push_back(in_data);
                mcnt[in_sel]++;
            end
        end
    end

    // Monitor: every take must deliver the oldest outstanding word of that channel.
    always @(negedge clk) begin
        logic [W-1:0] e;
        #1;
        if (chk_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("take_empty_ch%0d", i), 64'd1, 64'd0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk($sformatf("data_ch%0d", i), 64'(od[i]), 64'(e));
                        chk($sformatf("data_w4_ch%0d", i), 64'(od4[i]), 64'(e));
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic release_rst();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #0.5;
            chk($sformatf("ready_after_rst_sel%0d", s), 64'(in_ready), 64'd1);
        end
        in_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            mcnt[i] = 0;
        end
        chk_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_cnt"}, 64'(out_cnt), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_data"}, 64'({out_data0, out_data1, out_data2, out_data3}), 64'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        release_rst();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'd0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        release_rst();

        // single write, then blocked second write to a full channel
        drive(1'b1, 2'd2, 8'hA5, 4'b0000);
        drive(1'b1, 2'd2, 8'h11, 4'b0000);
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 64'h4);
        chk("single_data2", 64'(out_data2), 64'hA5);
        chk("full_blocks", 64'(in_ready), 64'd0);
        drive(1'b1, 2'd0, 8'h5A, 4'b0000);
        @(negedge clk);
        chk("other_ch_ready", 64'(in_ready), 64'd1);

        // back-pressure holds data, then drain-and-refill in one cycle
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 8'h00, 4'b0000);
            @(negedge clk);
            chk("stall_data2", 64'(out_data2), 64'hA5);
        end
        drive(1'b1, 2'd2, 8'h3C, 4'b0100);
        @(negedge clk);
        chk("refill_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
        chk("refill_data2", 64'(out_data2), 64'h3C);
        chk("refill_valid2", 64'(out_valid[2]), 64'd1);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);

        // streaming at one word per cycle
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'd1, 8'(k), 4'b0010);
            @(negedge clk);
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 2'd0, 8'h00, 4'b0010);
        @(negedge clk);
        chk("stream_cnt1", 64'(out_cnt[15:8]), 64'd16);
        chk("stream_cnt1_w4", 64'(cnt4[7:4]), 64'd0);

        // mid-traffic reset with words still buffered
        for (int k = 0; k < 20; k++)
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'b0000);
        reset_pulse();

        // counter wrap on the narrow instance
        for (int k = 0; k < 17; k++) drive(1'b1, 2'd3, 8'(k + 100), 4'b1000);
        drive(1'b0, 2'd0, 8'h00, 4'b1000);
        @(negedge clk);
        chk("wrap_cnt_w4", 64'(cnt4), 64'h1000);
        chk("wrap_cnt", 64'(out_cnt), 64'h1100_0000);

        // random traffic
        for (int k = 0; k < 10000; k++)
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom),
                  4'($urandom_range(0, 15)));
        for (int k = 0; k < 3; k++) drive(1'b0, 2'd0, 8'h00, 4'b1111);
        @(negedge clk);
        #2;
        for (int i = 0; i < 4; i++)
            chk($sformatf("drained_ch%0d", i), 64'(sbq[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
